mult_seq: RTL

- Iterative radix-2 shift-add multiplier for the CPU's MULT/MULTU path; the multiply counterpart of the sequential divider in the same EX stage.
- Takes two 32-bit operands on a start pulse and returns the 64-bit product as hi/lo after 32 iterations.
- Holds busy while working so the pipeline can stall HI/LO reads.

---
 rtl/mult_seq.sv | 92 +++++++++
 1 files changed

// File: rtl/mult_seq.sv
// mult_seq: iterative radix-2 shift-add multiplier used by the EX stage for
// MULT/MULTU. The operands are latched on start. The unit then runs one
// shift-add step per clock. After WIDTH steps it writes the signed or unsigned
// 2*WIDTH-bit product to hi/lo.
// All state updates on the falling edge of clock.
//
// Ports:
//   clock        system clock (falling-edge active)
//   reset_n      asynchronous reset, active-low
//   multiplicand operand A, sampled on start
//   multiplier   operand B, sampled on start
//   signed_op    1 = two's-complement multiply, 0 = unsigned; sampled on start
//   start        begin (or restart) an operation; level-sampled every edge
//   hi, lo       registered product, upper/lower halves
//   busy         high while iterating
//   done         one-cycle pulse when hi/lo are written
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             signed_op,
  input  logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, mq, mcand;
  logic             neg;

  // Operand magnitudes. A signed -2^(WIDTH-1) negates to itself. Read as
  // unsigned, that value is exactly 2^(WIDTH-1), so no extra bit is needed.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = signed_op & multiplicand[WIDTH-1];
  assign b_neg = signed_op & multiplier[WIDTH-1];
  assign a_mag = a_neg ? (~multiplicand + 1'b1) : multiplicand;
  assign b_mag = b_neg ? (~multiplier + 1'b1)   : multiplier;

  // One shift-add step. The adder's carry drops into acc's MSB through the
  // right shift, so the 2*WIDTH-bit partial product never overflows.
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_nxt, mq_nxt;
  logic [2*WIDTH-1:0] prod, result;
  assign sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = sum[WIDTH:1];
  assign mq_nxt  = {sum[0], mq[WIDTH-1:1]};
  assign prod    = {acc_nxt, mq_nxt};
  assign result  = neg ? (~prod + 1'b1) : prod;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Start wins over iteration, so a start while busy aborts and restarts.
        mcand <= a_mag;
        mq    <= b_mag;
        acc   <= '0;
        neg   <= a_neg ^ b_neg;
        count <= '0;
        busy  <= 1'b1;
      end else if (busy) begin
        acc   <= acc_nxt;
        mq    <= mq_nxt;
        count <= count + 1'b1;
        if (count == CW'(WIDTH-1)) begin
          {hi, lo} <= result;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule
